// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame FSM states, data-width
// limits and the oversample counter width helper.
package uart_pkg;

  localparam int DATA_W_MIN   = 5;
  localparam int DATA_W_LIMIT = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Width of a counter that runs 0..ovs-1; never narrower than one bit.
  function automatic int ovs_cnt_w(input int ovs);
    return (ovs <= 2) ? 1 : $clog2(ovs);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered storage; the head entry is presented on
// o_data whenever o_empty is low. DEPTH must be a power of two.
module uart_tx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [6:0]       o_level
);

  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = 7'(r_count);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter with per-word frame configuration. Optional input FIFO is
// built when UART_TX_FIFO_EN is defined; otherwise a single holding register.
module uart_tx_gen
  import uart_pkg::*;
#(
  parameter int DATA_W_MAX = 9,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [DATA_W_MAX-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            data_bits_i,
  input  logic                  par_en_i,
  input  logic                  par_odd_i,
  input  logic                  stop2_i,
  output logic                  txd_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [6:0]            level_o,
  output logic [2:0]            dbg_state_o
);

  localparam int CW = ovs_cnt_w(OVS);
  localparam int WW = DATA_W_MAX + 7;
  localparam logic [CW-1:0] OVS_LAST = CW'(OVS - 1);

  // Handshake: a word moves on a clk edge where valid_i && ready_o; the
  // frame configuration travels with the word so later changes are ignored.
  logic [WW-1:0]         w_in_word;
  logic [WW-1:0]         w_word;
  logic                  w_word_avail;
  logic                  w_load;
  logic [DATA_W_MAX-1:0] w_w_data;
  logic [3:0]            w_w_bits;
  logic                  w_w_par_en;
  logic                  w_w_par_odd;
  logic                  w_w_stop2;
  logic [3:0]            w_nbits;
  logic                  w_par;
  logic                  w_bit_end;

  uart_state_e           r_state, n_state;
  logic [CW-1:0]         r_ovs, n_ovs;
  logic [3:0]            r_bit, n_bit;
  logic [DATA_W_MAX-1:0] r_shift, n_shift;
  logic [3:0]            r_nbits, n_nbits;
  logic                  r_par, n_par;
  logic                  r_par_en, n_par_en;
  logic                  r_stop2, n_stop2;
  logic                  r_txd, n_txd;
  logic                  r_done, n_done;

  assign w_in_word = {stop2_i, par_odd_i, par_en_i, data_bits_i, data_i};

`ifdef UART_TX_FIFO_EN
  logic w_full;
  logic w_empty;

  uart_tx_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (valid_i && !w_full),
    .i_data  (w_in_word),
    .i_pop   (w_load),
    .o_data  (w_word),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_o)
  );

  assign ready_o      = !w_full;
  assign w_word_avail = !w_empty;
`else
  logic          r_hold_valid;
  logic [WW-1:0] r_hold;

  assign ready_o      = (r_state == IDLE) && !r_hold_valid;
  assign w_word       = r_hold;
  assign w_word_avail = r_hold_valid;
  assign level_o      = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
    end else if (valid_i && ready_o) begin
      r_hold_valid <= 1'b1;
      r_hold       <= w_in_word;
    end else if (w_load) begin
      r_hold_valid <= 1'b0;
    end
  end
`endif

  assign w_w_data    = w_word[DATA_W_MAX-1:0];
  assign w_w_bits    = w_word[DATA_W_MAX+3:DATA_W_MAX];
  assign w_w_par_en  = w_word[DATA_W_MAX+4];
  assign w_w_par_odd = w_word[DATA_W_MAX+5];
  assign w_w_stop2   = w_word[DATA_W_MAX+6];

  assign w_nbits = (w_w_bits < 4'(DATA_W_MIN)) ? 4'(DATA_W_MIN) :
                   (w_w_bits > 4'(DATA_W_MAX)) ? 4'(DATA_W_MAX) : w_w_bits;

  // Parity covers only the bits that will actually be sent.
  always_comb begin
    w_par = w_w_par_odd;
    for (int i = 0; i < DATA_W_MAX; i++) begin
      if (4'(i) < w_nbits) w_par = w_par ^ w_w_data[i];
    end
  end

  assign w_bit_end = clk_en && (r_ovs == OVS_LAST);

  always_comb begin
    n_state  = r_state;
    n_ovs    = r_ovs;
    n_bit    = r_bit;
    n_shift  = r_shift;
    n_nbits  = r_nbits;
    n_par    = r_par;
    n_par_en = r_par_en;
    n_stop2  = r_stop2;
    n_done   = 1'b0;
    w_load   = 1'b0;

    if (r_state != IDLE && clk_en) n_ovs = w_bit_end ? '0 : r_ovs + 1'b1;

    case (r_state)
      IDLE: begin
        if (w_word_avail) w_load = 1'b1;
      end
      START: begin
        if (w_bit_end) begin
          n_state = DATA;
          n_bit   = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit == r_nbits - 4'd1) begin
            n_state = r_par_en ? PARITY : STOP;
            n_bit   = '0;
          end else begin
            n_bit   = r_bit + 4'd1;
            n_shift = r_shift >> 1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          n_state = STOP;
          n_bit   = '0;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && r_bit == 4'd0) begin
            n_bit = 4'd1;
          end else begin
            n_done = 1'b1;
            if (w_word_avail) w_load = 1'b1;
            else              n_state = IDLE;
          end
        end
      end
      default: n_state = IDLE;
    endcase

    // Frame start (from IDLE or straight out of STOP) loads the next word.
    if (w_load) begin
      n_state  = START;
      n_ovs    = '0;
      n_bit    = '0;
      n_shift  = w_w_data;
      n_nbits  = w_nbits;
      n_par    = w_par;
      n_par_en = w_w_par_en;
      n_stop2  = w_w_stop2;
    end

    case (n_state)
      START:   n_txd = 1'b0;
      DATA:    n_txd = n_shift[0];
      PARITY:  n_txd = n_par;
      default: n_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ovs    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_nbits  <= '0;
      r_par    <= 1'b0;
      r_par_en <= 1'b0;
      r_stop2  <= 1'b0;
      r_txd    <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= n_state;
      r_ovs    <= n_ovs;
      r_bit    <= n_bit;
      r_shift  <= n_shift;
      r_nbits  <= n_nbits;
      r_par    <= n_par;
      r_par_en <= n_par_en;
      r_stop2  <= n_stop2;
      r_txd    <= n_txd;
      r_done   <= n_done;
    end
  end

  assign txd_o       = r_txd;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = r_done;
  assign dbg_state_o = r_state;

endmodule
